// File: rtl/lsu_pkg.sv
// Shared decode constants, FSM state type and access-size helper for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } lsu_state_t;

    // Access size in bytes; 0 marks an encoding with no defined width.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = 3'd1;
            F3_H, F3_HU: f3_size = 3'd2;
            F3_W:        f3_size = 3'd4;
            default:     f3_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane datapath: load extraction with extension, and store merge into a {hi,lo} word pair.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged_lo,
    output logic [31:0] o_merged_hi
);

    logic [63:0] w_pair;
    logic [63:0] w_shift;
    logic [63:0] w_merged;

    assign w_pair  = {i_hi, i_lo};
    assign w_shift = w_pair >> {i_off, 3'b000};

    // Pick the low bytes of the shifted window and extend to 32 bits.
    always_comb begin
        o_load = w_shift[31:0];
        case (i_size)
            3'd1: o_load = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
            3'd2: o_load = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
            default: o_load = w_shift[31:0];
        endcase
    end

    // Overwrite lanes off..off+size-1 with the low store bytes; other lanes keep their read value.
    always_comb begin
        w_merged = w_pair;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(i_size)) begin
                w_merged[8*(int'(i_off)+i) +: 8] = i_wdata[8*i +: 8];
            end
        end
    end

    assign o_merged_lo = w_merged[31:0];
    assign o_merged_hi = w_merged[63:32];

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer: turns byte/half/word accesses into whole-word memory reads and writes.
//
// state   | meaning
// IDLE    | waiting for a request
// RD_LO   | reading the word holding the first byte
// RD_HI   | reading the following word of a spanning access
// WR_LO   | writing the merged low word
// WR_HI   | writing the merged high word
// DONE    | one-cycle completion, rdata/err valid
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter logic [31:0] RESET_RDATA      = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_err,
    output logic        o_busy,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_t  r_state, w_next;
    logic        r_we, r_err;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata, r_lo, r_hi, r_rdata;

    logic [2:0]  w_in_size, w_size;
    logic        w_in_span, w_in_err, w_span;
    logic [31:0] w_addr_lo, w_addr_hi, w_load, w_mlo, w_mhi;

    assign w_in_size = f3_size(i_funct3);
    assign w_in_span = ({1'b0, i_addr[1:0]} + w_in_size) > 3'd4;
    assign w_in_err  = (w_in_size == 3'd0) || (i_we && i_funct3[2]) ||
                       (w_in_span && !ALLOW_MISALIGNED);

    assign w_size    = f3_size(r_funct3);
    assign w_span    = ({1'b0, r_addr[1:0]} + w_size) > 3'd4;
    assign w_addr_lo = {r_addr[31:2], 2'b00};
    assign w_addr_hi = w_addr_lo + 32'd4;

    lsu_lane_merge u_lane (
        .i_lo        (r_lo),
        .i_hi        (r_hi),
        .i_off       (r_addr[1:0]),
        .i_size      (w_size),
        .i_signed    (~r_funct3[2]),
        .i_wdata     (r_wdata),
        .o_load      (w_load),
        .o_merged_lo (w_mlo),
        .o_merged_hi (w_mhi)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state selection; aligned SW skips the read since every lane is overwritten.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    if (w_in_err)                                     w_next = S_DONE;
                    else if (i_we && i_funct3 == F3_W && i_addr[1:0] == 2'b00) w_next = S_WR_LO;
                    else                                              w_next = S_RD_LO;
                end
            end
            S_RD_LO: w_next = w_span ? S_RD_HI : (r_we ? S_WR_LO : S_DONE);
            S_RD_HI: w_next = r_we ? S_WR_LO : S_DONE;
            S_WR_LO: w_next = w_span ? S_WR_HI : S_DONE;
            S_WR_HI: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; address and write data are forced to zero outside memory cycles.
    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_done      = (r_state == S_DONE);
        o_err       = (r_state == S_DONE) && r_err;
        o_mem_read  = (r_state == S_RD_LO) || (r_state == S_RD_HI);
        o_mem_write = (r_state == S_WR_LO) || (r_state == S_WR_HI);
        o_mem_addr  = 32'h0;
        o_mem_wdata = 32'h0;
        case (r_state)
            S_RD_LO: o_mem_addr = w_addr_lo;
            S_RD_HI: o_mem_addr = w_addr_hi;
            S_WR_LO: begin o_mem_addr = w_addr_lo; o_mem_wdata = w_mlo; end
            S_WR_HI: begin o_mem_addr = w_addr_hi; o_mem_wdata = w_mhi; end
            default: ;
        endcase
        o_rdata = (o_done && !r_we && !r_err) ? w_load : r_rdata;
    end

    // Request capture, read-word capture and held load result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_lo     <= 32'h0;
            r_hi     <= 32'h0;
            r_rdata  <= RESET_RDATA;
        end else begin
            case (r_state)
                S_IDLE: if (i_req) begin
                    r_we     <= i_we;
                    r_err    <= w_in_err;
                    r_funct3 <= i_funct3;
                    r_addr   <= i_addr;
                    r_wdata  <= i_wdata;
                end
                S_RD_LO: r_lo <= i_mem_rdata;
                S_RD_HI: r_hi <= i_mem_rdata;
                S_DONE:  if (!r_we && !r_err) r_rdata <= w_load;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model and a no-misaligned variant.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, req, req2, we, load_mem;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, m_addr, m_wdata, m_rdata;
    logic        done, err, busy, m_rd, m_wr;
    logic [31:0] rdata2, m2_addr, m2_wdata, m2_rdata;
    logic        done2, err2, busy2, m2_rd, m2_wr;

    logic [31:0] mem [0:15];
    int          n_checks = 0;
    int          n_errors = 0;

    int          res_lat, res_nrd, res_nwr;
    logic        res_both, res_busy_all, res_err;
    logic [31:0] res_rdata, rd_a0, rd_a1;

    always #5 clk = ~clk;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1), .RESET_RDATA(32'h0)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_done(done), .o_err(err),
        .o_busy(busy), .o_mem_read(m_rd), .o_mem_write(m_wr), .o_mem_addr(m_addr),
        .o_mem_wdata(m_wdata), .i_mem_rdata(m_rdata)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0), .RESET_RDATA(32'h0)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_req(req2), .i_we(we), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata2), .o_done(done2), .o_err(err2),
        .o_busy(busy2), .o_mem_read(m2_rd), .o_mem_write(m2_wr), .o_mem_addr(m2_addr),
        .o_mem_wdata(m2_wdata), .i_mem_rdata(m2_rdata)
    );

    assign m_rdata  = mem[m_addr[5:2]];
    assign m2_rdata = mem[m2_addr[5:2]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2] <= 32'hDEADBEEF;
            mem[3] <= 32'h12345678;
        end else if (m_wr) begin
            mem[m_addr[5:2]] <= m_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload();
        @(negedge clk); load_mem = 1'b1;
        @(negedge clk); load_mem = 1'b0;
    endtask

    // Issue one request and watch the DUT until done (bounded); returns at the DONE-cycle negedge.
    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        res_lat = 0; res_nrd = 0; res_nwr = 0; res_both = 1'b0; res_busy_all = 1'b1;
        res_err = 1'b0; res_rdata = 32'hX; rd_a0 = 32'hX; rd_a1 = 32'hX;
        for (int k = 1; k <= 10; k++) begin
            if (!busy) res_busy_all = 1'b0;
            if (m_rd && m_wr) res_both = 1'b1;
            if (m_rd) begin
                if (res_nrd == 0) rd_a0 = m_addr; else rd_a1 = m_addr;
                res_nrd++;
            end
            if (m_wr) res_nwr++;
            if (done) begin
                res_lat = k; res_rdata = rdata; res_err = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0; load_mem = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_strobes", {30'b0, m_rd, m_wr}, 32'h0);
        chk("rst_maddr", m_addr, 32'h0);
        chk("rst_mwdata", m_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);

        preload();
        access(1'b0, 3'b010, 32'h8, 32'h0);
        chk("lw_rdata", res_rdata, 32'hDEADBEEF);
        chk("lw_lat", res_lat, 2);
        chk("lw_nwr", res_nwr, 0);
        chk("lw_err", {31'b0, res_err}, 32'h0);
        chk("lw_rdaddr", rd_a0, 32'h8);

        access(1'b0, 3'b000, 32'h9, 32'h0);
        chk("lb_rdata", res_rdata, 32'hFFFFFFBE);
        chk("lb_lat", res_lat, 2);
        access(1'b0, 3'b100, 32'h9, 32'h0);
        chk("lbu_rdata", res_rdata, 32'h000000BE);
        access(1'b0, 3'b001, 32'hA, 32'h0);
        chk("lh_rdata", res_rdata, 32'hFFFFDEAD);
        access(1'b0, 3'b101, 32'hA, 32'h0);
        chk("lhu_rdata", res_rdata, 32'h0000DEAD);
        @(negedge clk);
        chk("rdata_held", rdata, 32'h0000DEAD);

        preload();
        access(1'b1, 3'b000, 32'hA, 32'h00000055);
        chk("sb_lat", res_lat, 3);
        chk("sb_nrd", res_nrd, 1);
        chk("sb_nwr", res_nwr, 1);
        @(negedge clk);
        chk("sb_mem8", mem[2], 32'hDE55BEEF);
        chk("sb_memC", mem[3], 32'h12345678);

        preload();
        access(1'b1, 3'b010, 32'hC, 32'hCAFEF00D);
        chk("sw_lat", res_lat, 2);
        chk("sw_nrd", res_nrd, 0);
        @(negedge clk);
        chk("sw_memC", mem[3], 32'hCAFEF00D);
        chk("sw_mem8", mem[2], 32'hDEADBEEF);

        preload();
        access(1'b0, 3'b010, 32'hA, 32'h0);
        chk("lwm_rdata", res_rdata, 32'h5678DEAD);
        chk("lwm_lat", res_lat, 3);
        chk("lwm_rd0", rd_a0, 32'h8);
        chk("lwm_rd1", rd_a1, 32'hC);

        access(1'b1, 3'b001, 32'hB, 32'h0000A1B2);
        chk("shm_lat", res_lat, 5);
        chk("shm_busy", {31'b0, res_busy_all}, 32'h1);
        chk("shm_both", {31'b0, res_both}, 32'h0);
        chk("shm_nwr", res_nwr, 2);
        @(negedge clk);
        chk("shm_mem8", mem[2], 32'hB2ADBEEF);
        chk("shm_memC", mem[3], 32'h123456A1);

        access(1'b0, 3'b011, 32'h8, 32'h0);
        chk("ill_lat", res_lat, 1);
        chk("ill_err", {31'b0, res_err}, 32'h1);
        chk("ill_strobes", res_nrd + res_nwr, 0);
        chk("ill_rdata", res_rdata, 32'h5678DEAD);
        access(1'b1, 3'b100, 32'h8, 32'h0);
        chk("sbu_err", {31'b0, res_err}, 32'h1);
        chk("sbu_nwr", res_nwr, 0);

        access(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
        chk("wrap_rd0", rd_a0, 32'hFFFFFFFC);
        chk("wrap_rd1", rd_a1, 32'h0);
        chk("wrap_lat", res_lat, 3);

        // Variant that refuses spanning accesses.
        preload();
        @(negedge clk);
        req2 = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'hA;
        @(negedge clk);
        req2 = 1'b0;
        chk("nm_done", {31'b0, done2}, 32'h1);
        chk("nm_err", {31'b0, err2}, 32'h1);
        chk("nm_strobes", {30'b0, m2_rd, m2_wr}, 32'h0);
        chk("nm_rdata", rdata2, 32'h0);

        // Reset while the spanning store is in RD_HI.
        preload();
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'hB; wdata = 32'h0000A1B2;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("abort_in_rdhi", m_addr, 32'hC);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_strobes", {30'b0, m_rd, m_wr}, 32'h0);
        chk("abort_maddr", m_addr, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        res_nwr = 0;
        for (int k = 0; k < 6; k++) begin
            if (m_wr) res_nwr++;
            @(negedge clk);
        end
        chk("abort_nwr", res_nwr, 0);
        chk("abort_mem8", mem[2], 32'hDEADBEEF);
        chk("abort_memC", mem[3], 32'h12345678);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage (ALU address, rs2 data, funct3) and the word-wide DataMemory.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into whole-word DataMemory reads and writes.
- Sub-word stores become read-modify-write sequences; misaligned halfword/word accesses become two-word sequences.
- Core stalls on busy and consumes rdata on the done pulse.

Parameters:
- ALLOW_MISALIGNED, 1, 1: split word-spanning accesses into two words; 0: flag them err with no memory access.
- RESET_RDATA, 32'h00000000, value of rdata after reset.

Ports:
- clk  input  1  system clock, all state changes on posedge
- rst  input  1  synchronous, active-high reset
- req  input  1  access request, sampled only when busy=0
- we  input  1  1=store, 0=load
- funct3  input  3  RV32I width/sign code
- addr  input  32  byte address
- wdata  input  32  store data (rs2), low bytes used for SB/SH
- rdata  output  32  load result, extended to 32 bits
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: illegal funct3, or misaligned with ALLOW_MISALIGNED=0
- busy  output  1  high whenever state != IDLE
- MemRead  output  1  DataMemory read strobe
- MemWrite  output  1  DataMemory write strobe
- mem_addr  output  32  word-aligned address, [1:0]=00
- mem_wdata  output  32  DataMemory write word
- mem_rdata  input  32  DataMemory read word, valid combinationally in the same cycle as MemRead

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; busy=0, done=0, err=0, MemRead=0, MemWrite=0, mem_addr=0, mem_wdata=0, rdata=RESET_RDATA.
- Reset mid-operation aborts the sequence. No MemWrite is issued in or after the reset cycle. Partially merged data is discarded.
- Accept: in IDLE with req=1 at posedge, register we/funct3/addr/wdata. Requests while busy are ignored, never queued.
- funct3 decode: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned. 100/101 with we=1 are illegal. 011/110/111 are illegal.
- off=addr[1:0]. Spans when off+size>4: half with off=3, word with off!=0. Bytes never span.
- Low word address: {addr[31:2],2'b00}. High word address: low+4, wrapping 0xFFFFFFFC -> 0x00000000.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- Load: IDLE->RD_LO->[RD_HI if spans]->DONE.
- Aligned SW: IDLE->WR_LO->DONE.
- Other stores: IDLE->RD_LO->[RD_HI]->WR_LO->[WR_HI]->DONE.
- Illegal access: IDLE->DONE with err=1, rdata unchanged, no strobes.
- Spanning access with ALLOW_MISALIGNED=0: same as illegal (IDLE->DONE, err=1, no strobes).
- MemRead=1 only in RD_LO/RD_HI. MemWrite=1 only in WR_LO/WR_HI. The two strobes are never both high. mem_rdata is captured at the end of each RD state.
- Byte order is little-endian. Load bytes come from the {hi,lo} 64-bit concatenation starting at off. Stores merge bytes into captured words at lanes off..off+size-1 and leave other bytes unchanged.
- rdata is updated in the DONE cycle and held until the next successful load. It is sign- or zero-extended per funct3.
- done=1 for exactly one cycle in DONE. Next state is IDLE, so back-to-back requests have a 1-cycle gap.
- Latency from accept edge to done: aligned LW/SW 2; LB/LH/LBU/LHU 2; SB/aligned SH 3; spanning load 3; spanning store 5; illegal 1.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum lsu_state_t;
  - size-from-funct3 function.
- Sub-module lsu_lane_merge: combinational byte extract/sign-extend and byte-lane merge for a given off/size. The FSM stays in load_store_unit.

Test Plan:
- Preload mem[0x8]=0xDEADBEEF, mem[0xC]=0x12345678 for all scenarios.
- LW addr=0x8 -> rdata=0xDEADBEEF, done 2 cycles after accept, MemWrite never high, err=0.
- LB addr=0x9 -> rdata=0xFFFFFFBE; LBU addr=0x9 -> rdata=0x000000BE; LH addr=0xA -> 0xFFFFDEAD.
- SB addr=0xA wdata=0x00000055 -> RD_LO,WR_LO,DONE; mem[0x8]=0xDE55BEEF, mem[0xC] untouched, done 3 cycles after accept.
- LW addr=0xA (misaligned) -> MemRead at 0x8 then 0xC; rdata=0x5678DEAD, done at cycle 3. With ALLOW_MISALIGNED=0: err=1, no strobes.
- SH addr=0xB wdata=0x0000A1B2 -> mem[0x8]=0xB2ADBEEF, mem[0xC]=0x123456A1, done at cycle 5, busy high throughout.
- funct3=011 -> done+err next cycle, no strobes, rdata unchanged.
- SH 0xB with rst pulsed in RD_HI -> no MemWrite ever, memory unchanged, all outputs at reset values next cycle.
